// File: rtl/branch_redirect_ctrl_if.sv
// rtl/branch_redirect_ctrl_if.sv - EX-stage branch request and fetch-side redirect bundle
interface branch_redirect_ctrl_if;
  logic        stall_in;
  logic        ex_valid_in;
  logic        ex_is_cti_in;
  logic        branch_taken_in;
  logic [31:0] target_in;
  logic [31:0] pc_out;
  logic        redirect_out;
  logic        flush_if_out;
  logic        flush_id_out;
  logic        squash_ex_out;
  logic        misaligned_out;
  logic        busy_out;
  logic [15:0] redirect_cnt_out;

  modport master (
    output stall_in, ex_valid_in, ex_is_cti_in, branch_taken_in, target_in,
    input  pc_out, redirect_out, flush_if_out, flush_id_out, squash_ex_out,
           misaligned_out, busy_out, redirect_cnt_out
  );

  modport slave (
    input  stall_in, ex_valid_in, ex_is_cti_in, branch_taken_in, target_in,
    output pc_out, redirect_out, flush_if_out, flush_id_out, squash_ex_out,
           misaligned_out, busy_out, redirect_cnt_out
  );
endinterface

// File: rtl/branch_redirect_ctrl.sv
// rtl/branch_redirect_ctrl.sv - fetch PC sequencer with taken-CTI redirect and squash window
module branch_redirect_ctrl #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter logic [31:0] TRAP_VEC     = 32'h0000_0100,
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic                  clk_in,
  input  logic                  rst_in,
  branch_redirect_ctrl_if.slave bus
);

  typedef enum logic {RUN = 1'b0, FLUSH = 1'b1} state_t;

  localparam logic [3:0] CNT_INIT = 4'(FLUSH_CYCLES - 1);

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] redirect_cnt_q, redirect_cnt_d;
  logic        accept;
  logic        misaligned;

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      pc_q           <= RESET_PC;
      redirect_cnt_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      pc_q           <= pc_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    pc_d           = pc_q;
    redirect_cnt_d = redirect_cnt_q;
    // Reset masks the pulses so nothing escapes while the pipe is being cleared.
    accept     = (state_q == RUN) && bus.ex_valid_in && bus.ex_is_cti_in &&
                 bus.branch_taken_in && !bus.stall_in && !rst_in;
    misaligned = accept && (bus.target_in[1:0] != 2'b00);
    if (!bus.stall_in) begin
      case (state_q)
        RUN: begin
          if (accept) begin
            pc_d           = misaligned ? TRAP_VEC : bus.target_in;
            redirect_cnt_d = redirect_cnt_q + 16'd1;
            state_d        = FLUSH;
            cnt_d          = CNT_INIT;
          end else begin
            pc_d = pc_q + 32'd4;
          end
        end
        FLUSH: begin
          pc_d = pc_q + 32'd4;
          if (cnt_q == 4'd0) state_d = RUN;
          else               cnt_d   = cnt_q - 4'd1;
        end
      endcase
    end
  end

  assign bus.pc_out           = pc_q;
  assign bus.redirect_out     = accept;
  assign bus.flush_if_out     = accept;
  assign bus.flush_id_out     = accept;
  assign bus.misaligned_out   = misaligned;
  assign bus.squash_ex_out    = (state_q == FLUSH);
  assign bus.busy_out         = (state_q == FLUSH);
  assign bus.redirect_cnt_out = redirect_cnt_q;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// tb/tb_branch_redirect_ctrl.sv - scoreboard bench for branch_redirect_ctrl
module tb_branch_redirect_ctrl;

  localparam int FLUSH = 2;

  typedef struct {
    logic [31:0] pc;
    logic        redirect;
    logic        flush_if;
    logic        flush_id;
    logic        squash;
    logic        mis;
    logic        busy;
    logic [15:0] rcnt;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   compared   = 0;
  int   mismatched = 0;
  exp_t sb_q[$];

  // Reference state: PC, remaining squash cycles, redirect count.
  logic [31:0] m_pc;
  int          m_window;
  logic [15:0] m_count;

  branch_redirect_ctrl_if bus ();

  branch_redirect_ctrl #(
    .RESET_PC(32'h0000_0000), .TRAP_VEC(32'h0000_0100), .FLUSH_CYCLES(FLUSH)
  ) dut (
    .clk_in(clk), .rst_in(rst), .bus(bus.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic s, input logic v, input logic c,
                      input logic t, input logic [31:0] tgt, input bit push);
    exp_t e;
    bit   take;
    @(negedge clk);
    rst                 = r;
    bus.stall_in        = s;
    bus.ex_valid_in     = v;
    bus.ex_is_cti_in    = c;
    bus.branch_taken_in = t;
    bus.target_in       = tgt;
    take       = !r && (m_window == 0) && v && c && t && !s;
    e.pc       = m_pc;
    e.redirect = take;
    e.flush_if = take;
    e.flush_id = take;
    e.mis      = take && (tgt[1:0] != 2'b00);
    e.squash   = (m_window > 0);
    e.busy     = (m_window > 0);
    e.rcnt     = m_count;
    if (push) sb_q.push_back(e);
    if (r) begin
      m_pc     = 32'h0;
      m_window = 0;
      m_count  = 16'h0;
    end else if (!s) begin
      if (take) begin
        m_pc     = (tgt[1:0] != 2'b00) ? 32'h100 : tgt;
        m_window = FLUSH;
        m_count  = m_count + 16'd1;
      end else begin
        m_pc = m_pc + 32'd4;
        if (m_window > 0) m_window--;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
  endtask

  task automatic taken(input logic [31:0] tgt);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, tgt, 1'b1);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (sb_q.size() > 0) begin
        e = sb_q.pop_front();
        chk("pc_out",           bus.pc_out,                   e.pc);
        chk("redirect_out",     32'(bus.redirect_out),        32'(e.redirect));
        chk("flush_if_out",     32'(bus.flush_if_out),        32'(e.flush_if));
        chk("flush_id_out",     32'(bus.flush_id_out),        32'(e.flush_id));
        chk("squash_ex_out",    32'(bus.squash_ex_out),       32'(e.squash));
        chk("misaligned_out",   32'(bus.misaligned_out),      32'(e.mis));
        chk("busy_out",         32'(bus.busy_out),            32'(e.busy));
        chk("redirect_cnt_out", 32'(bus.redirect_cnt_out),    32'(e.rcnt));
      end
    end
  end

  initial begin : stimulus
    logic        r, s, v, c, t;
    logic [31:0] tgt;
    rst                 = 1'b1;
    bus.stall_in        = 1'b0;
    bus.ex_valid_in     = 1'b0;
    bus.ex_is_cti_in    = 1'b0;
    bus.branch_taken_in = 1'b0;
    bus.target_in       = 32'h0;
    m_pc     = 32'h0;
    m_window = 0;
    m_count  = 16'h0;

    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(4);
    taken(32'h40);
    idle(3);
    step(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h42, 1'b1);
    idle(3);
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h200, 1'b1);
    taken(32'h200);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 32'h300, 1'b1);
    idle(3);
    taken(32'h80);
    taken(32'h400);
    taken(32'h500);
    idle(3);
    taken(32'h600);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    idle(3);
    taken(32'hFFFF_FFF8);
    idle(4);

    // Preload the redirect counter to its wrap point while the block is frozen.
    @(posedge clk);
    #1;
    force dut.redirect_cnt_q = 16'hFFFF;
    m_count = 16'hFFFF;
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1);
    @(posedge clk);
    #1;
    release dut.redirect_cnt_q;
    taken(32'h700);
    idle(3);

    for (int i = 0; i < 1500; i++) begin
      r   = ($urandom_range(0, 99) == 0);
      s   = ($urandom_range(0, 4) == 0);
      v   = ($urandom_range(0, 3) != 0);
      c   = 1'($urandom_range(0, 1));
      t   = 1'($urandom_range(0, 1));
      tgt = $urandom;
      if ($urandom_range(0, 3) != 0) tgt[1:0] = 2'b00;
      step(r, s, v, c, t, tgt, 1'b1);
    end
    idle(2);

    repeat (5) @(negedge clk);
    compared++;
    if (sb_q.size() != 0) begin
      mismatched++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
